// File: rtl/hub75_bram_fetcher_if.sv
// Signal bundle between the scan controller, the BRAM read port and the HUB75 shift-out
// stage, seen from the fetcher (slave) and from its surroundings (master).
interface hub75_bram_fetcher_if #(
    parameter int LINE_W  = 5,
    parameter int COLOR_W = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 64
);
    // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
    // once valid is raised the payload stays stable and valid stays high until that edge.
    logic              req_valid;
    logic [LINE_W-1:0] req_line;
    logic              req_ready;

    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [COLOR_W-1:0] out_color;
    logic               out_last;
    logic               busy;

    modport master (
        output req_valid, req_line, bram_data, out_ready,
        input  req_ready, bram_en, bram_addr, out_valid, out_data, out_color, out_last, busy
    );

    modport slave (
        input  req_valid, req_line, bram_data, out_ready,
        output req_ready, bram_en, bram_addr, out_valid, out_data, out_color, out_last, busy
    );
endinterface

// File: rtl/hub75_bram_fetcher.sv
// Walks every bit-plane of one requested HUB75 line, reads it from BRAM and streams the
// border-masked words out. Define HUB75_DEAD_READ_EN for legacy blank-word reads on dead planes.
module hub75_bram_fetcher #(
    parameter int LINES        = 32,
    parameter int COLORS       = 6,
    parameter int PLANE_STRIDE = 64,
    parameter int HALF_OFFSET  = 32,
    parameter int DEAD_TOP     = LINES - 1,
    parameter int DEAD_BOT     = LINES - 2,
    parameter int ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] DEAD_ADDR = 8'hFF,
    parameter int DATA_W       = 64,
    parameter int BORDER_W     = 2,
    parameter int BRAM_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    hub75_bram_fetcher_if.slave   bus,
    output logic [1:0]            dbg_state
);
    localparam int LINE_W  = $clog2(LINES);
    localparam int COLOR_W = $clog2(COLORS);
    localparam int HALF    = COLORS / 2;
    localparam int CNT_W   = $clog2(BRAM_LAT + 1);
    localparam logic [DATA_W-1:0] KEEP_MASK = {{BORDER_W{1'b0}}, {(DATA_W-BORDER_W){1'b1}}};

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               last_q, last_d;

    logic               upper;
    int                 plane_idx;
    logic [LINE_W-1:0]  line_next;
    logic               dead;
    logic               plane_reads;
    logic               is_last;
    logic               issue_en;
    logic [ADDR_W-1:0]  map_addr;
    logic [ADDR_W-1:0]  issue_addr;

    // Plane geometry for the current (line, colour): address mapping and dead-line test.
    always_comb begin
        upper      = int'(color_q) >= HALF;
        plane_idx  = upper ? int'(color_q) - HALF : int'(color_q);
        line_next  = line_q + LINE_W'(1);
        map_addr   = ADDR_W'(plane_idx * PLANE_STRIDE + (upper ? HALF_OFFSET : 0) + int'(line_next));
        dead       = upper ? (line_q == LINE_W'(DEAD_BOT)) : (line_q == LINE_W'(DEAD_TOP));
        issue_addr = dead ? DEAD_ADDR : map_addr;
        is_last    = (color_q == COLOR_W'(COLORS - 1));
`ifdef HUB75_DEAD_READ_EN
        plane_reads = 1'b1;
`else
        plane_reads = !dead;
`endif
    end

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        color_d  = color_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        last_d   = last_q;
        issue_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    line_d  = bus.req_line;
                    color_d = '0;
                    last_d  = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (plane_reads) begin
                    issue_en = 1'b1;
                    cnt_d    = CNT_W'(BRAM_LAT);
                    state_d  = WAIT;
                end else begin
                    // Dead plane without a read: blank word generated locally.
                    data_d  = '0;
                    last_d  = is_last;
                    state_d = HOLD;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    data_d  = (bus.bram_data >> 1) & KEEP_MASK;
                    last_d  = is_last;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                    end else begin
                        color_d = color_q + COLOR_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            color_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            color_q <= color_d;
            cnt_q   <= cnt_d;
            addr_q  <= bus.bram_addr;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // The address port keeps its previous value between reads.
    assign bus.bram_en   = issue_en;
    assign bus.bram_addr = issue_en ? issue_addr : addr_q;
    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = data_q;
    assign bus.out_color = color_q;
    assign bus.out_last  = last_q;
    assign dbg_state     = state_q;
endmodule

// File: doc/hub75_bram_fetcher.md
# hub75_bram_fetcher

- Sequential, parametrised successor to the combinational HUB75 line/colour BRAM address mapper.
- Accepts one display line per request, walks all `COLORS` bit-planes of that line, issues BRAM reads with a configurable read latency, applies the border transform, and streams one plane word per valid/ready beat.
- Sits between the scan controller (requester) and the HUB75 shift-out stage (consumer).

## Interface
- `LINES`, 32: lines per half-panel; power of two.
- `COLORS`, 6: planes per line; even. Planes `[0, COLORS/2)` form the top half, the rest form the bottom half.
- `PLANE_STRIDE`, 64: address distance between planes of the same half.
- `HALF_OFFSET`, 32: extra base offset for bottom-half planes.
- `DEAD_TOP`, `LINES-1`: dead line for top-half planes.
- `DEAD_BOT`, `LINES-2`: dead line for bottom-half planes.
- `DEAD_ADDR`, 8'hFF: blank-word address, used only under the macro.
- `ADDR_W`, 8: BRAM address width.
- `DATA_W`, 64: word width.
- `BORDER_W`, 2: zeroed MSBs (right border).
- `BRAM_LAT`, 1: BRAM read latency in cycles; must be ≥1.
- `clk`  in  1  sole clock; everything is sampled on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  line request valid.
- `req_line`  in  $clog2(LINES)  line index.
- `req_ready`  out  1  high only in IDLE.
- `bram_en`  out  1  read strobe.
- `bram_addr`  out  ADDR_W  read address.
- `bram_data`  in  DATA_W  read data, valid `BRAM_LAT` cycles after `bram_en`.
- `out_valid`  out  1  plane word valid.
- `out_ready`  in  1  consumer accept.
- `out_data`  out  DATA_W  transformed word.
- `out_color`  out  $clog2(COLORS)  plane index of `out_data`.
- `out_last`  out  1  high with the final plane of a line.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- **Address for line `l`, plane `c`:**
  - `h = c >= COLORS/2`
  - `p = c - h*COLORS/2`
  - `addr = p*PLANE_STRIDE + h*HALF_OFFSET + ((l+1) mod LINES)`
  - Compute in ADDR_W bits; overflow wraps modulo 2^ADDR_W.
- **Dead plane:** a plane is dead when `l == DEAD_TOP` for a top-half plane, or `l == DEAD_BOT` for a bottom-half plane.
- **Transform:** `out_data = (bram_data >> 1)` with bits `[DATA_W-1 : DATA_W-BORDER_W]` forced to 0.
- **FSM states:** IDLE, ISSUE, WAIT, HOLD.
  - **IDLE:** `req_ready`=1. On `req_valid`, latch `req_line`, set `c`=0, go to ISSUE.
  - **ISSUE:** one cycle.
    - Live plane: `bram_en`=1 with `addr`. Go to WAIT, loading a latency counter with `BRAM_LAT`.
    - Dead plane: `bram_en`=0. Load the output register with all zeros and go directly to HOLD.
  - **WAIT:** decrement the counter each cycle. When it expires, capture the transformed `bram_data` into the output register and go to HOLD.
  - **HOLD:** `out_valid`=1, with `out_color`=`c` and `out_last`=(`c`==COLORS-1).
    - On `out_ready` with `c`<COLORS-1: increment `c`, go to ISSUE.
    - On `out_ready` with `out_last`: go to IDLE.
- `out_data`, `out_color` and `out_last` are registered and stay stable while `out_valid`=1 and `out_ready`=0.
- A `req_valid` arriving outside IDLE is not accepted. The requester holds it until `req_ready`.
- `bram_addr` holds its last value while `bram_en`=0. The BRAM must not be assumed idle-addressed.

## Timing
- **Reset values:**
  - state IDLE, `req_ready`=1, `busy`=0
  - `bram_en`=0, `bram_addr`=0
  - `out_valid`=0, `out_data`=0, `out_color`=0, `out_last`=0
  - latched line and plane counters = 0
- **Mid-operation reset:** `rst` asserted in any state aborts the line immediately, with no further `bram_en` or `out_valid`.
- **Request to first issue:** `req_valid`&`req_ready` at edge N → `bram_en` high in cycle N+1.
- **Live plane:** `bram_en` in cycle K → `out_valid` in cycle K+1+BRAM_LAT.
- **Dead plane:** ISSUE in cycle K → `out_valid` in cycle K+1.
- **Plane to plane:** accept at edge M → next ISSUE in cycle M+1.
- **Zero-backpressure line time:** COLORS·(2+BRAM_LAT) cycles for all-live planes.
- **Last plane:** accept at edge M → `req_ready`=1 in cycle M+1. No request is accepted in the same cycle as the last `out_ready`.

## Configuration
- **`HUB75_DEAD_READ_EN` defined:** dead planes behave like live planes, with `bram_en`=1, `bram_addr`=`DEAD_ADDR`, and full WAIT latency. The data is transformed like any other word. This is the legacy blank-word behaviour.
- **Undefined (default):** dead planes issue no BRAM read and emit internally generated zeros after one cycle.

## Test plan
- **Reset values:** after reset → all outputs at their reset values. Assert `rst` while in WAIT on plane 2 → `out_valid` never asserts, state is IDLE, `req_ready`=1.
- **Line 0, defaults, `out_ready` tied 1:**
  - Addresses 1, 65, 129, 33, 97, 161 in order.
  - `out_color` 0..5, `out_last` only with colour 5.
  - Each `out_data` equals the stored word >>1 with bits 63:62 = 0; a stored 64'hFFFF_FFFF_FFFF_FFFF gives 64'h3FFF_FFFF_FFFF_FFFF.
- **Line 31, defaults, macro undefined:**
  - Planes 0–2 emit zero data with no `bram_en`.
  - Planes 3–5 read addresses 32, 96, 160.
- **Line 30, defaults, macro undefined:**
  - Planes 0–2 read addresses 31, 95, 159.
  - Planes 3–5 are dead: zero data, no `bram_en`.
- **Backpressure:** `out_ready` low for 5 cycles on plane 1 → `out_valid` and `out_data` held stable, no further `bram_en` until accept, and no dropped or duplicated plane.
- **`BRAM_LAT`=3 with macro defined, line 31:** planes 0–2 read `DEAD_ADDR` (8'hFF) and each `out_valid` appears exactly 4 cycles after its `bram_en`.
